// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum output is enabled with IMEM_LOAD_CHECKSUM_EN.
package imem_pkg;

  typedef enum logic {
    IDLE,
    WRITE
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IMEM_DEPTH     = 1024;
  localparam int unsigned CNT_W          = 16;

  // Big-endian byte select: beat 0 returns the most significant byte.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] beat);
    return w[31 - 8 * beat -: 8];
  endfunction

endpackage

// File: rtl/imem_word_serializer.sv
// Splits one latched 32-bit word into four registered big-endian byte writes.
// Unaffected by IMEM_LOAD_CHECKSUM_EN.
module imem_word_serializer
  import imem_pkg::*;
#(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned IWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IWIDTH-1:0] word,
  input  logic [AWIDTH-1:0] base,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              done
);

  logic [1:0]        beat_q;
  logic [IWIDTH-1:0] word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      beat_q    <= '0;
      word_q    <= '0;
    end else if (start) begin
      mem_we    <= 1'b1;
      mem_addr  <= base;
      mem_wdata <= byte_sel(word, 2'd0);
      beat_q    <= '0;
      word_q    <= word;
    end else if (mem_we) begin
      if (beat_q == 2'd3) begin
        mem_we <= 1'b0;
      end else begin
        beat_q    <= beat_q + 2'd1;
        mem_addr  <= mem_addr + AWIDTH'(1);
        mem_wdata <= byte_sel(word_q, beat_q + 2'd1);
      end
    end
  end

  // High during the cycle that carries the last byte.
  assign done = mem_we & (beat_q == 2'd3);

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory loader/arbiter: accepts words, writes them bytewise, gates CPU fetch.
// Define IMEM_LOAD_CHECKSUM_EN to add the ld_csum running-sum output.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned IWIDTH = 32,
  parameter int unsigned DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [IWIDTH-1:0] ld_data,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              fetch_req,
  output logic              fetch_grant,
  output logic              fetch_stall,
  output logic              load_busy,
  output logic              ld_err,
`ifdef IMEM_LOAD_CHECKSUM_EN
  output logic [IWIDTH-1:0] ld_csum,
`endif
  output logic [CNT_W-1:0]  words_loaded
);

  localparam int unsigned AW1 = AWIDTH + 1;

  state_e           state_q;
  logic             load_en_q;
  logic             ready_q;
  logic             ld_err_q;
  logic [CNT_W-1:0] words_q;
  logic             session_start;
  logic             accept;
  logic             addr_ok;
  logic             ser_start;
  logic             ser_done;
  logic [AW1-1:0]   last_byte;

  assign session_start = load_en & ~load_en_q;

  // ready_q mirrors "idle" but stays low while in reset.
  assign ld_ready  = load_en & ready_q;
  assign accept    = ld_valid & ld_ready;
  assign last_byte = {1'b0, ld_addr} + AW1'(BYTES_PER_WORD - 1);
  assign addr_ok   = (ld_addr[1:0] == 2'b00) && (last_byte < AW1'(DEPTH));
  assign ser_start = accept & addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      load_en_q <= 1'b0;
      ready_q   <= 1'b0;
      ld_err_q  <= 1'b0;
      words_q   <= '0;
    end else begin
      load_en_q <= load_en;
      if (session_start) begin
        ld_err_q <= 1'b0;
        words_q  <= '0;
      end else if (ser_done && (words_q != '1)) begin
        words_q <= words_q + CNT_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (addr_ok) begin
              state_q <= WRITE;
              ready_q <= 1'b0;
            end else begin
              ld_err_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          ready_q <= 1'b0;
          if (ser_done) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  imem_word_serializer #(
    .AWIDTH(AWIDTH),
    .IWIDTH(IWIDTH)
  ) u_serializer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (ser_start),
    .word     (ld_data),
    .base     (ld_addr),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .done     (ser_done)
  );

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [IWIDTH-1:0] csum_word_q;
  logic [IWIDTH-1:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_word_q <= '0;
      csum_q      <= '0;
    end else begin
      if (ser_start) csum_word_q <= ld_data;
      if (session_start) csum_q <= '0;
      else if (ser_done) csum_q <= csum_q + csum_word_q;
    end
  end

  assign ld_csum = csum_q;
`endif

  assign load_busy    = (state_q == WRITE);
  assign ld_err       = ld_err_q;
  assign words_loaded = words_q;
  assign fetch_grant  = fetch_req & ~load_en & (state_q == IDLE);
  assign fetch_stall  = fetch_req & ~fetch_grant;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: directed scenarios plus random traffic vs a queue model.
// Build with IMEM_LOAD_CHECKSUM_EN to also check ld_csum.
module tb_imem_load_ctrl;
  import imem_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 32;
  localparam int unsigned DP = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_en = 1'b0;
  logic          ld_valid = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [IW-1:0] ld_data = '0;
  logic          ld_ready, mem_we, fetch_grant, fetch_stall, load_busy, ld_err;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [15:0]   words_loaded;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [IW-1:0] ld_csum;
`endif

  imem_load_ctrl #(.AWIDTH(AW), .IWIDTH(IW), .DEPTH(DP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .fetch_req   (fetch_req),
    .fetch_grant (fetch_grant),
    .fetch_stall (fetch_stall),
    .load_busy   (load_busy),
    .ld_err      (ld_err),
`ifdef IMEM_LOAD_CHECKSUM_EN
    .ld_csum     (ld_csum),
`endif
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pending byte writes in a queue, plus session counters.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  wr_t           wq[$];
  logic [15:0]   m_words = '0;
  logic          m_err = 1'b0;
  logic [IW-1:0] m_csum = '0;
  logic [IW-1:0] m_word = '0;
  logic          m_prev_en = 1'b0;
  logic          m_ready_ok = 1'b0;
  logic          m_acc = 1'b0;

  task automatic model_reset();
    wq.delete();
    m_words = '0;
    m_err = 1'b0;
    m_csum = '0;
    m_prev_en = 1'b0;
    m_ready_ok = 1'b0;
    m_acc = 1'b0;
  endtask

  task automatic model_edge();
    logic idle, start, last;
    wr_t  e;
    idle  = (wq.size() == 0);
    last  = (wq.size() == 1);
    start = load_en & ~m_prev_en;
    m_acc = ld_valid & load_en & idle & m_ready_ok;
    if (!idle) void'(wq.pop_front());
    if (start) begin
      m_err = 1'b0;
      m_words = '0;
      m_csum = '0;
    end else if (last) begin
      if (m_words != 16'hFFFF) m_words = m_words + 16'd1;
      m_csum = m_csum + m_word;
    end
    if (m_acc) begin
      if ((ld_addr % 4 == 0) && (64'(ld_addr) + 64'd3 < 64'(DP))) begin
        m_word = ld_data;
        for (int b = 0; b < 4; b++) begin
          e.a = ld_addr + 32'(b);
          e.d = 8'(ld_data >> (24 - 8 * b));
          wq.push_back(e);
        end
      end else begin
        m_err = 1'b1;
      end
    end
    m_prev_en = load_en;
    m_ready_ok = 1'b1;
  endtask

  task automatic compare_all();
    logic idle, grant;
    idle  = (wq.size() == 0);
    grant = fetch_req & ~load_en & idle;
    check("mem_we", mem_we, !idle);
    if (!idle) begin
      check("mem_addr", mem_addr, wq[0].a);
      check("mem_wdata", mem_wdata, wq[0].d);
    end
    check("ld_ready", ld_ready, load_en & idle & m_ready_ok);
    check("load_busy", load_busy, !idle);
    check("ld_err", ld_err, m_err);
    check("words_loaded", words_loaded, m_words);
    check("fetch_grant", fetch_grant, grant);
    check("fetch_stall", fetch_stall, fetch_req & ~grant);
`ifdef IMEM_LOAD_CHECKSUM_EN
    check("ld_csum", ld_csum, m_csum);
`endif
  endtask

  // Called at a negedge with inputs already set for the coming posedge.
  task automatic step();
    #1;
    compare_all();
    model_edge();
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, output int n);
    n = 0;
    ld_valid = 1'b1;
    ld_addr = a;
    ld_data = d;
    do begin
      step();
      n++;
    end while (!m_acc && n < 30);
    check("accept_timeout", m_acc, 1'b1);
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_load_busy", load_busy, 1'b0);
    check("rst_ld_err", ld_err, 1'b0);
    check("rst_words", words_loaded, 16'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 8'd0);
    check("rst_fetch_grant", fetch_grant, fetch_req & ~load_en);
`ifdef IMEM_LOAD_CHECKSUM_EN
    check("rst_csum", ld_csum, 32'd0);
`endif
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1, 2, 3: return 32'($urandom_range(0, DP / 4 - 1)) * 4;
      4: return DP - 4;
      5: return 32'($urandom_range(0, DP - 1)) | 32'd1;
      6: return DP + 32'($urandom_range(0, 255)) * 4;
      default: return 32'hFFFF_FFFC;
    endcase
  endfunction

  int n;

  initial begin
    @(negedge clk);
    reset_now();

    // Fetch granted while no session is active.
    fetch_req = 1'b1;
    repeat (3) step();

    // Single word; fetch stalls once load_en rises.
    load_en = 1'b1;
    step();
    send(32'h10, 32'hDEAD_BEEF, n);
    ld_valid = 1'b0;
    repeat (6) step();
    check("single_words", words_loaded, 16'd1);

    // Back-to-back with ld_valid held high.
    send(32'h0, 32'h1111_2222, n);
    send(32'h4, 32'h3333_4444, n);
    check("b2b_gap1", n, 5);
    send(32'h8, 32'hF000_0001, n);
    check("b2b_gap2", n, 5);
    ld_valid = 1'b0;
    repeat (6) step();
    check("b2b_words", words_loaded, 16'd4);

    // Misaligned and out-of-range words are dropped; a good word still lands.
    send(32'h2, 32'hAAAA_AAAA, n);
    send(32'h3FE0 + DP, 32'hBBBB_BBBB, n);
    send(32'h20, 32'h0102_0304, n);
    ld_valid = 1'b0;
    repeat (6) step();
    check("err_sticky", ld_err, 1'b1);

    // Drop load_en mid-write: grant returns only after the last beat.
    send(32'h40, 32'hCAFE_F00D, n);
    ld_valid = 1'b0;
    step();
    load_en = 1'b0;
    repeat (6) step();

    // Reset during beat 1.
    load_en = 1'b1;
    step();
    send(32'h30, 32'h5566_7788, n);
    ld_valid = 1'b0;
    step();
    reset_now();
    repeat (2) step();

    // New session clears error and count.
    load_en = 1'b0;
    step();
    load_en = 1'b1;
    step();
    send(32'h6, 32'h1, n);
    for (int i = 0; i < 5; i++) send(32'(i * 4 + 32'h100), $urandom(), n);
    ld_valid = 1'b0;
    repeat (6) step();
    check("sess_words", words_loaded, 16'd5);
    load_en = 1'b0;
    step();
    load_en = 1'b1;
    step();
    check("new_sess_err", ld_err, 1'b0);
    check("new_sess_words", words_loaded, 16'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) load_en = ~load_en;
      fetch_req = 1'($urandom_range(0, 1));
      ld_valid = ($urandom_range(0, 9) < 6);
      ld_addr = rand_addr();
      ld_data = $urandom();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
